bip_control_unit: RTL and testbench

BIP_CONTROL_UNIT -- requirements
Module: bip_control_unit

---
 rtl/bip_control_unit.sv | 202 ++++++++++++++++++++
 tb/tb_bip_control_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// Purpose : sequencing FSM for the BIP accumulator CPU; fetches, decodes and
//           executes one 16-bit instruction at a time (opcode [15:11], operand [10:0]).
// Latency : 3 cycles per instruction (FETCH-DECODE-EXEC); 4 for LD/ADD/SUB (adds MEM).
// Backpressure: none; runs free once started, HLT parks the FSM until reset.
//
// Ports:
//   clk, reset        - single clock; synchronous active-high reset
//   start             - leaves IDLE; ignored in every other state
//   instruction[15:0] - program-memory word at the current PC
//   wr_pc             - one-cycle PC increment enable (EXEC only)
//   operand[10:0]     - latched IR[10:0]: data-memory address and immediate
//   sel_a[1:0]        - accumulator source: 00 memory, 01 immediate, 10 ALU
//   sel_b             - ALU operand B: 0 memory, 1 immediate
//   op_sub            - ALU function: 0 add, 1 subtract
//   wr_acc, wr_ram    - accumulator / data-memory write strobes
//   rd_ram            - data-memory read strobe (MEM only)
//   halted            - high while parked in HALT
//   instr_count[15:0] - executed-instruction counter, only when the macro
//                       BIP_CYCLE_COUNTER_EN is defined (wraps at 0xFFFF)
//
// Every output is decoded from state_q and ir_q only, so nothing on
// instruction or start reaches an output combinationally.

module bip_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] instruction,
    output logic        wr_pc,
    output logic [10:0] operand,
    output logic [1:0]  sel_a,
    output logic        sel_b,
    output logic        op_sub,
    output logic        wr_acc,
    output logic        wr_ram,
    output logic        rd_ram,
    output logic        halted
`ifdef BIP_CYCLE_COUNTER_EN
    ,
    output logic [15:0] instr_count
`endif
);

    // Opcode map
    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    // Accumulator source select encodings
    localparam logic [1:0] SEL_A_MEM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [4:0]  opcode;

    assign opcode = ir_q[15:11];

    // ------------------------------------------------------------------
    // State and instruction register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // IR captures the word at the PC as FETCH ends and holds it
                // through DECODE/MEM/EXEC.
                ir_d    = instruction;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_HLT:                state_d = S_HALT;
                    OP_LD, OP_ADD, OP_SUB: state_d = S_MEM;
                    // STO, immediates and every undefined opcode (NOP)
                    default:               state_d = S_EXEC;
                endcase
            end
            S_MEM:    state_d = S_EXEC;
            S_EXEC:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode (Moore: state_q + ir_q only)
    // ------------------------------------------------------------------
    always_comb begin
        wr_pc   = 1'b0;
        sel_a   = SEL_A_MEM;
        sel_b   = 1'b0;
        op_sub  = 1'b0;
        wr_acc  = 1'b0;
        wr_ram  = 1'b0;
        rd_ram  = (state_q == S_MEM);
        halted  = (state_q == S_HALT);
        operand = ir_q[10:0];

        if (state_q == S_EXEC) begin
            // Every executed instruction, NOPs included, advances the PC
            // exactly once; HLT never reaches EXEC so never advances it.
            wr_pc = 1'b1;
            case (opcode)
                OP_STO: begin
                    wr_ram = 1'b1;
                end
                OP_LD: begin
                    wr_acc = 1'b1;
                    sel_a  = SEL_A_MEM;
                end
                OP_LDI: begin
                    wr_acc = 1'b1;
                    sel_a  = SEL_A_IMM;
                end
                OP_ADD: begin
                    wr_acc = 1'b1;
                    sel_a  = SEL_A_ALU;
                end
                OP_ADDI: begin
                    wr_acc = 1'b1;
                    sel_a  = SEL_A_ALU;
                    sel_b  = 1'b1;
                end
                OP_SUB: begin
                    wr_acc = 1'b1;
                    sel_a  = SEL_A_ALU;
                    op_sub = 1'b1;
                end
                OP_SUBI: begin
                    wr_acc = 1'b1;
                    sel_a  = SEL_A_ALU;
                    sel_b  = 1'b1;
                    op_sub = 1'b1;
                end
                default: begin
                    // NOP: only the PC advance
                end
            endcase
        end
    end

`ifdef BIP_CYCLE_COUNTER_EN
    // ------------------------------------------------------------------
    // Executed-instruction counter: one count per wr_pc, free wrap at 16 bits.
    // wr_pc is never high in HALT, so the count freezes there naturally.
    // ------------------------------------------------------------------
    logic [15:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (wr_pc) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 16'h0000;
        end else begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// Purpose : directed self-checking bench for bip_control_unit with a tiny
//           program memory and PC model around the DUT.
// Latency : outputs sampled on the falling edge, inputs driven there too.
// Backpressure: n/a.

module tb_bip_control_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] instruction;
    logic        wr_pc;
    logic [10:0] operand;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op_sub;
    logic        wr_acc;
    logic        wr_ram;
    logic        rd_ram;
    logic        halted;
`ifdef BIP_CYCLE_COUNTER_EN
    logic [15:0] instr_count;
`endif

    bip_control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instruction (instruction),
        .wr_pc       (wr_pc),
        .operand     (operand),
        .sel_a       (sel_a),
        .sel_b       (sel_b),
        .op_sub      (op_sub),
        .wr_acc      (wr_acc),
        .wr_ram      (wr_ram),
        .rd_ram      (rd_ram),
        .halted      (halted)
`ifdef BIP_CYCLE_COUNTER_EN
        ,
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory and program counter around the control unit
    logic [15:0] prog [16];
    logic [10:0] pc;

    always @(posedge clk) begin
        if (reset)      pc <= 11'd0;
        else if (wr_pc) pc <= pc + 11'd1;
    end

    assign instruction = prog[pc[3:0]];

    // Control-word layout: {halted, wr_pc, sel_a[1:0], sel_b, op_sub, wr_acc, wr_ram, rd_ram}
    localparam logic [8:0] C_NONE = 9'h000;
    localparam logic [8:0] C_RD   = 9'h001;
    localparam logic [8:0] C_HALT = 9'h100;
    localparam logic [8:0] X_LDI  = 9'h0A4;  // wr_pc, sel_a=01, wr_acc
    localparam logic [8:0] X_ADD  = 9'h0C4;  // wr_pc, sel_a=10, wr_acc
    localparam logic [8:0] X_LD   = 9'h084;  // wr_pc, sel_a=00, wr_acc
    localparam logic [8:0] X_ADDI = 9'h0D4;  // wr_pc, sel_a=10, sel_b, wr_acc
    localparam logic [8:0] X_SUBI = 9'h0DC;  // wr_pc, sel_a=10, sel_b, op_sub, wr_acc
    localparam logic [8:0] X_SUB  = 9'h0CC;  // wr_pc, sel_a=10, op_sub, wr_acc
    localparam logic [8:0] X_NOP  = 9'h080;  // wr_pc only
    localparam logic [8:0] X_STO  = 9'h082;  // wr_pc, wr_ram

    int          n_vec;
    int          n_err;
    int          cyc;
    int          last_pc;
    int          gap;
    int          pc_pulses;
    int          ram_writes;
    logic [8:0]  ctl;
    logic [10:0] opnd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance to the next falling edge and capture the outputs of this cycle.
    task automatic smp();
        @(negedge clk);
        cyc++;
        ctl  = {halted, wr_pc, sel_a, sel_b, op_sub, wr_acc, wr_ram, rd_ram};
        opnd = operand;
        if (wr_pc) begin
            gap     = cyc - last_pc;
            last_pc = cyc;
            pc_pulses++;
        end
        if (wr_ram) ram_writes++;
    endtask

    // Walk one instruction from FETCH entry to the end of EXEC.
    task automatic run_instr(input string name, input logic [10:0] exp_opnd,
                             input bit has_mem, input logic [8:0] exp_exec,
                             input int exp_period, input bit check_period);
        int p0;
        p0 = pc_pulses;
        smp();
        start = 1'b0;
        chk({name, "/fetch"}, 32'(ctl), 32'(C_NONE));
        smp();
        chk({name, "/decode"}, 32'(ctl), 32'(C_NONE));
        chk({name, "/dec_opnd"}, 32'(opnd), 32'(exp_opnd));
        if (has_mem) begin
            smp();
            chk({name, "/mem"}, 32'(ctl), 32'(C_RD));
            chk({name, "/mem_opnd"}, 32'(opnd), 32'(exp_opnd));
        end
        smp();
        chk({name, "/exec"}, 32'(ctl), 32'(exp_exec));
        chk({name, "/exec_opnd"}, 32'(opnd), 32'(exp_opnd));
        chk({name, "/wr_pc_cnt"}, 32'(pc_pulses - p0), 32'd1);
        if (check_period) begin
            chk({name, "/period"}, 32'(gap), 32'(exp_period));
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; last_pc = 0; gap = 0;
        pc_pulses = 0; ram_writes = 0;
        reset = 1'b1;
        start = 1'b0;
        prog[0]  = 16'h1805;  // LDI  0x005
        prog[1]  = 16'h2010;  // ADD  0x010
        prog[2]  = 16'h1020;  // LD   0x020
        prog[3]  = 16'h2807;  // ADDI 0x007
        prog[4]  = 16'h3803;  // SUBI 0x003
        prog[5]  = 16'hF800;  // undefined -> NOP
        prog[6]  = 16'h0FFF;  // STO  0x7FF
        prog[7]  = 16'h0000;  // HLT
        for (int i = 8; i < 16; i++) prog[i] = 16'h0000;

        // Reset state
        smp();
        smp();
        chk("reset/ctl", 32'(ctl), 32'(C_NONE));
        chk("reset/operand", 32'(opnd), 32'd0);

        // Idle without start stays idle
        reset = 1'b0;
        smp();
        smp();
        chk("idle/ctl", 32'(ctl), 32'(C_NONE));

        // Program run
        start = 1'b1;
        run_instr("ldi",  11'h005, 1'b0, X_LDI,  3, 1'b0);
        run_instr("add",  11'h010, 1'b1, X_ADD,  4, 1'b1);
        run_instr("ld",   11'h020, 1'b1, X_LD,   4, 1'b1);
        run_instr("addi", 11'h007, 1'b0, X_ADDI, 3, 1'b1);
        run_instr("subi", 11'h003, 1'b0, X_SUBI, 3, 1'b1);
        run_instr("nop",  11'h000, 1'b0, X_NOP,  3, 1'b1);
        run_instr("sto",  11'h7FF, 1'b0, X_STO,  3, 1'b1);

        // HLT: halted two cycles after its FETCH entry
        smp();
        chk("hlt/fetch", 32'(ctl), 32'(C_NONE));
        smp();
        chk("hlt/decode", 32'(ctl), 32'(C_NONE));
        smp();
        chk("hlt/halted", 32'(ctl), 32'(C_HALT));
        chk("hlt/ram_writes", 32'(ram_writes), 32'd1);

        // start pulses while halted change nothing
        begin
            int p0;
            p0 = pc_pulses;
            for (int i = 0; i < 3; i++) begin
                start = 1'b1;
                smp();
                start = 1'b0;
                chk("halt/start_hi", 32'(ctl), 32'(C_HALT));
                smp();
                chk("halt/start_lo", 32'(ctl), 32'(C_HALT));
            end
            chk("halt/no_wr_pc", 32'(pc_pulses - p0), 32'd0);
            chk("halt/ram_writes", 32'(ram_writes), 32'd1);
        end

        // Reset wins over start; block stays idle afterwards
        reset = 1'b1;
        start = 1'b1;
        prog[0] = 16'h3003;  // SUB 0x003
        smp();
        chk("rst_pri/ctl", 32'(ctl), 32'(C_NONE));
        chk("rst_pri/operand", 32'(opnd), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("rst_pri/idle", 32'(ctl), 32'(C_NONE));
        end

        // Reset asserted during MEM of SUB
        start = 1'b1;
        smp();
        start = 1'b0;
        chk("sub/fetch", 32'(ctl), 32'(C_NONE));
        smp();
        chk("sub/dec_opnd", 32'(opnd), 32'h003);
        smp();
        chk("sub/mem", 32'(ctl), 32'(C_RD));
        reset = 1'b1;
        smp();
        reset = 1'b0;
        chk("midrst/ctl", 32'(ctl), 32'(C_NONE));
        chk("midrst/operand", 32'(opnd), 32'd0);
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("midrst/idle", 32'(ctl), 32'(C_NONE));
        end

        // Full SUB after restart
        start = 1'b1;
        run_instr("sub", 11'h003, 1'b1, X_SUB, 4, 1'b0);
        reset = 1'b1;
        smp();
        reset = 1'b0;

`ifdef BIP_CYCLE_COUNTER_EN
        // 70000 LDIs: count wraps to 70000 - 65536 = 4464
        for (int i = 0; i < 16; i++) prog[i] = 16'h1805;
        reset = 1'b1;
        smp();
        reset = 1'b0;
        chk("cnt/reset", 32'(instr_count), 32'd0);
        start = 1'b1;
        smp();
        start = 1'b0;
        for (int i = 1; i < 210000; i++) smp();
        // now in EXEC of the 70000th LDI; one more cycle registers it
        smp();
        chk("cnt/wrap", 32'(instr_count), 32'd4464);
        for (int i = 0; i < 16; i++) prog[i] = 16'h0000;
        smp();
        smp();
        chk("cnt/halted", 32'(ctl), 32'(C_HALT));
        for (int i = 0; i < 3; i++) smp();
        chk("cnt/hold", 32'(instr_count), 32'd4464);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
